// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// conv_layer_sequencer : per-layer convolution sequencer + signed MAC engine
// Revision 1.0
// ============================================================================
module conv_layer_sequencer #(
   parameter int DATA_WIDTH      = 8,
   parameter int KERNEL_SIZE     = 3,
   parameter int INPUT_CHANNELS  = 3,
   parameter int OUTPUT_CHANNELS = 16,
   parameter int IMG_SIZE        = 8,
   parameter int ACC_WIDTH       = 24,
   parameter int SHIFT           = 0,
   localparam int N_TAPS = KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS,
   localparam int O_SIZE = IMG_SIZE-KERNEL_SIZE+1,
   localparam int IN_AW  = $clog2(INPUT_CHANNELS*IMG_SIZE*IMG_SIZE),
   localparam int W_AW   = $clog2(OUTPUT_CHANNELS*N_TAPS),
   localparam int OUT_AW = $clog2(OUTPUT_CHANNELS*O_SIZE*O_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  in_rd_en,
   output logic [IN_AW-1:0]      in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  w_rd_en,
   output logic [W_AW-1:0]       w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_AW-1:0]     out_addr,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int CW = 16;
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((2**(DATA_WIDTH-1))-1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] tap_q, tap_d, ic_q, ic_d, kx_q, kx_d, ky_q, ky_d;
   logic [CW-1:0] ox_q, ox_d, oy_q, oy_d, oc_q, oc_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic acc_vld_q, acc_vld_d, acc_first_q, acc_first_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic signed [2*DATA_WIDTH-1:0] prod_w;
   logic signed [ACC_WIDTH-1:0]    acc_sum_w, shifted_w;
   logic [DATA_WIDTH-1:0]          sat_w;
   logic                           last_pix_w;

   // Read data belongs to the tap issued one cycle earlier; acc_first_q marks tap 0.
   always_comb begin
      prod_w    = $signed(in_data) * $signed(w_data);
      acc_sum_w = acc_first_q ? ACC_WIDTH'(prod_w) : acc_q + ACC_WIDTH'(prod_w);
      acc_d     = acc_vld_q ? acc_sum_w : acc_q;
      shifted_w = acc_sum_w >>> SHIFT;
      if (shifted_w > SAT_HI)      sat_w = DATA_WIDTH'(SAT_HI);
      else if (shifted_w < SAT_LO) sat_w = DATA_WIDTH'(SAT_LO);
      else                         sat_w = DATA_WIDTH'(shifted_w);
   end

   assign last_pix_w = (ox_q == CW'(O_SIZE-1)) && (oy_q == CW'(O_SIZE-1)) &&
                       (oc_q == CW'(OUTPUT_CHANNELS-1));

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      ic_d        = ic_q;
      kx_d        = kx_q;
      ky_d        = ky_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      oc_d        = oc_q;
      out_data_d  = out_data_q;
      acc_vld_d   = 1'b0;
      acc_first_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               tap_d = '0; ic_d = '0; kx_d = '0; ky_d = '0;
               ox_d  = '0; oy_d = '0; oc_d = '0;
            end
         end
         S_FETCH: begin
            acc_vld_d   = 1'b1;
            acc_first_d = (tap_q == '0);
            if (tap_q == CW'(N_TAPS-1)) begin
               state_d = S_DRAIN;
               tap_d = '0; ic_d = '0; kx_d = '0; ky_d = '0;
            end else begin
               tap_d = tap_q + 1'b1;
               if (ic_q == CW'(INPUT_CHANNELS-1)) begin
                  ic_d = '0;
                  if (kx_q == CW'(KERNEL_SIZE-1)) begin
                     kx_d = '0;
                     ky_d = ky_q + 1'b1;
                  end else begin
                     kx_d = kx_q + 1'b1;
                  end
               end else begin
                  ic_d = ic_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            out_data_d = sat_w;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            if (out_ready) begin
               state_d = last_pix_w ? S_DONE : S_FETCH;
               if (ox_q == CW'(O_SIZE-1)) begin
                  ox_d = '0;
                  if (oy_q == CW'(O_SIZE-1)) begin
                     oy_d = '0;
                     oc_d = (oc_q == CW'(OUTPUT_CHANNELS-1)) ? '0 : oc_q + 1'b1;
                  end else begin
                     oy_d = oy_q + 1'b1;
                  end
               end else begin
                  ox_d = ox_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         ic_q        <= '0;
         kx_q        <= '0;
         ky_q        <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         oc_q        <= '0;
         acc_q       <= '0;
         acc_vld_q   <= 1'b0;
         acc_first_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         ic_q        <= ic_d;
         kx_q        <= kx_d;
         ky_q        <= ky_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         oc_q        <= oc_d;
         acc_q       <= acc_d;
         acc_vld_q   <= acc_vld_d;
         acc_first_q <= acc_first_d;
         out_data_q  <= out_data_d;
      end
   end

   // Addresses derive from registered counters only, so all are zero while in reset.
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign in_rd_en  = (state_q == S_FETCH);
   assign w_rd_en   = (state_q == S_FETCH);
   assign out_valid = (state_q == S_WRITE);
   assign out_data  = out_data_q;
   assign in_addr   = IN_AW'(ic_q) * IN_AW'(IMG_SIZE*IMG_SIZE)
                    + IN_AW'(oy_q + ky_q) * IN_AW'(IMG_SIZE)
                    + IN_AW'(ox_q + kx_q);
   assign w_addr    = W_AW'(oc_q) * W_AW'(N_TAPS) + W_AW'(tap_q);
   assign out_addr  = OUT_AW'(oc_q) * OUT_AW'(O_SIZE*O_SIZE)
                    + OUT_AW'(oy_q) * OUT_AW'(O_SIZE)
                    + OUT_AW'(ox_q);

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_conv_layer_sequencer : directed self-checking bench, IMG 4, K 3, IC 2, OC 2
// Revision 1.0
// ============================================================================
module tb_conv_layer_sequencer;

   localparam int IMG = 4;
   localparam int K   = 3;
   localparam int IC  = 2;
   localparam int OC  = 2;
   localparam int NT  = K*K*IC;       // 18 taps
   localparam int O   = IMG-K+1;      // 2
   localparam int NPIX = OC*O*O;      // 8
   localparam int PASS = NPIX*(NT+2); // 160

   logic clk = 1'b0;
   logic rst, start, out_ready;

   logic       busy, done, in_rd_en, w_rd_en, out_valid;
   logic [4:0] in_addr;
   logic [5:0] w_addr;
   logic [2:0] out_addr;
   logic [7:0] in_data, w_data, out_data;

   logic       s_busy, s_done, s_in_rd_en, s_w_rd_en, s_out_valid;
   logic [4:0] s_in_addr;
   logic [5:0] s_w_addr;
   logic [2:0] s_out_addr;
   logic [7:0] s_in_data, s_w_data, s_out_data;

   logic signed [7:0] in_mem [32];
   logic signed [7:0] w_mem  [36];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   conv_layer_sequencer #(
      .DATA_WIDTH(8), .KERNEL_SIZE(K), .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC),
      .IMG_SIZE(IMG), .ACC_WIDTH(24), .SHIFT(0)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
      .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
   );

   conv_layer_sequencer #(
      .DATA_WIDTH(8), .KERNEL_SIZE(K), .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC),
      .IMG_SIZE(IMG), .ACC_WIDTH(24), .SHIFT(8)
   ) u_sh (
      .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done),
      .in_rd_en(s_in_rd_en), .in_addr(s_in_addr), .in_data(s_in_data),
      .w_rd_en(s_w_rd_en), .w_addr(s_w_addr), .w_data(s_w_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr), .out_data(s_out_data)
   );

   // One-cycle-latency RAM models
   always @(posedge clk) begin
      if (in_rd_en)   in_data   <= in_mem[in_addr];
      if (w_rd_en)    w_data    <= w_mem[w_addr];
      if (s_in_rd_en) s_in_data <= in_mem[s_in_addr];
      if (s_w_rd_en)  s_w_data  <= w_mem[s_w_addr];
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_pix(input int p, input int sh);
      int oc, oy, ox, sum, s;
      oc = p / (O*O); oy = (p / O) % O; ox = p % O;
      sum = 0;
      for (int ky = 0; ky < K; ky++)
         for (int kx = 0; kx < K; kx++)
            for (int ic = 0; ic < IC; ic++)
               sum += int'(in_mem[ic*IMG*IMG + (oy+ky)*IMG + ox+kx]) *
                      int'(w_mem[oc*NT + (ky*K+kx)*IC + ic]);
      s = sum >>> sh;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic fill(input int mode, input int a, input int b);
      for (int i = 0; i < 32; i++) in_mem[i] = (mode == 0) ? 8'((i*7) % 11 - 5) : 8'(a);
      for (int i = 0; i < 36; i++) w_mem[i]  = (mode == 0) ? 8'((i*5) % 9 - 4)  : 8'(b);
   endtask

   // exp_d/exp_s < -1000 means "use the reference model"
   task automatic run_pass(input int stall, input bit poke, input int exp_d, input int exp_s);
      int cyc, pix, apix, tap, first_v, stall_left, hold_d, hold_a;
      int e_in, oc, oy, ox, ic, kx, ky;
      bit done_seen;
      pix = 0; apix = 0; tap = 0; first_v = -1; stall_left = stall; done_seen = 1'b0;
      hold_d = 0; hold_a = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done_seen && cyc < 2000) begin
         out_ready = (stall_left == 0);
         start = poke && (cyc == 30 || cyc == 95);
         if (in_rd_en) begin
            oc = apix / (O*O); oy = (apix / O) % O; ox = apix % O;
            ic = tap % IC; kx = (tap / IC) % K; ky = tap / (IC*K);
            e_in = ic*IMG*IMG + (oy+ky)*IMG + ox + kx;
            chk("w_addr", int'(w_addr), oc*NT + tap);
            chk("in_addr", int'(in_addr), e_in);
            tap++;
            if (tap == NT) begin tap = 0; apix++; end
         end
         if (out_valid) begin
            if (first_v < 0) first_v = cyc;
            if (out_ready) begin
               chk("out_addr", int'(out_addr), pix);
               chk("out_data", int'($signed(out_data)), (exp_d < -1000) ? ref_pix(pix, 0) : exp_d);
               chk("sh_data", int'($signed(s_out_data)), (exp_s < -1000) ? ref_pix(pix, 8) : exp_s);
               pix++;
            end else begin
               if (stall_left == stall) begin
                  hold_d = int'(out_data); hold_a = int'(out_addr);
               end
               chk("stall_data", int'(out_data), hold_d);
               chk("stall_addr", int'(out_addr), hold_a);
               chk("stall_rd", int'(in_rd_en | w_rd_en), 0);
               stall_left--;
            end
         end
         if (done) begin
            done_seen = 1'b1;
            chk("done_cyc", cyc, PASS + stall + 1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", int'(done_seen), 1);
      chk("npix", pix, NPIX);
      chk("first_valid", first_v, NT + 2);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_done"},  int'(done), 0);
      chk({tag, "_rd"},    int'({in_rd_en, w_rd_en}), 0);
      chk({tag, "_valid"}, int'(out_valid), 0);
      chk({tag, "_addrs"}, int'({in_addr, w_addr, out_addr}), 0);
      chk({tag, "_data"},  int'(out_data), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      fill(0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      // mixed-sign data, model-checked values and full address trace
      run_pass(0, 1'b0, -2000, -2000);
      // all ones: 18 taps of 1*1
      fill(1, 1, 1);
      run_pass(0, 1'b0, 18, 0);
      // positive saturation; shifted: 18*16129>>8 = 1134 -> 127
      fill(1, 127, 127);
      run_pass(0, 1'b0, 127, 127);
      // negative saturation; shifted: 18*(-16256)>>>8 = -1143 -> -128
      fill(1, -128, 127);
      run_pass(0, 1'b0, -128, -128);
      // 16*16*18 = 4608: saturates unshifted, 4608>>8 = 18 shifted
      fill(1, 16, 16);
      run_pass(0, 1'b0, 127, 18);
      // backpressure on the first result, plus starts pulsed while busy
      fill(0, 0, 0);
      run_pass(20, 1'b0, -2000, -2000);
      run_pass(0, 1'b1, -2000, -2000);

      // asynchronous reset in the middle of FETCH
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      chk("pre_rst_rd", int'(in_rd_en), 1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_pass(0, 1'b0, -2000, -2000);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
